// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM command scheduler: bus commands, FSM states
// and the address bit that marks a precharge-all.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_PREA = 3'd5,
        CMD_REF  = 3'd6
    } sdram_cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ACT      = 4'd1,
        ST_WAIT_RCD = 4'd2,
        ST_RW       = 4'd3,
        ST_PRE      = 4'd4,
        ST_WAIT_RP  = 4'd5,
        ST_PREA     = 4'd6,
        ST_WAIT_RPA = 4'd7,
        ST_REF      = 4'd8,
        ST_WAIT_RFC = 4'd9
    } sched_state_e;

    // Address bit that distinguishes PREA from a single-bank PRE on the bus.
    localparam int PREA_ADDR_BIT = 10;

    // Largest of three timing values, used to size the shared wait counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter with a sticky pending flag. The flag
// is raised every T_REF cycles and dropped when the scheduler issues REF; a
// tick that lands while the flag is already up is simply absorbed.
module sdram_refresh_timer #(
    parameter int T_REF = 1560
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic pending_o
);

    localparam int CW = $clog2(T_REF);
    localparam logic [CW-1:0] RELOAD = CW'(T_REF - 1);

    logic [CW-1:0] cnt_q;
    logic          pending_q;

    // Count down to zero, reload, and latch a refresh request; a new tick wins over a clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= RELOAD;
            pending_q <= 1'b0;
        end else if (cnt_q == '0) begin
            cnt_q     <= RELOAD;
            pending_q <= 1'b1;
        end else begin
            cnt_q <= cnt_q - CW'(1);
            if (clear_i) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/sdram_cmd_scheduler.sv
// Single-access SDRAM command sequencer. Tracks the open row of every bank,
// turns one accepted request into PRE/ACT/RD/WR with tRP/tRCD spacing, and
// folds periodic PREA/REF in between accesses. All bus outputs are registered.
module sdram_cmd_scheduler
    import sdram_pkg::*;
#(
    parameter int SDRAM_BANK_WIDTH = 2,
    parameter int SDRAM_ROW_WIDTH  = 13,
    parameter int SDRAM_COL_WIDTH  = 9,
    parameter int T_RCD            = 3,
    parameter int T_RP             = 3,
    parameter int T_RFC            = 9,
    parameter int T_REF            = 1560
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_write_i,
    input  logic [SDRAM_BANK_WIDTH-1:0] req_bank_i,
    input  logic [SDRAM_ROW_WIDTH-1:0]  req_row_i,
    input  logic [SDRAM_COL_WIDTH-1:0]  req_col_i,
    output logic                        cmd_valid_o,
    output logic [2:0]                  cmd_o,
    output logic [SDRAM_BANK_WIDTH-1:0] cmd_bank_o,
    output logic [SDRAM_ROW_WIDTH-1:0]  cmd_addr_o,
    output logic                        refresh_pending_o
);

    localparam int NB = 1 << SDRAM_BANK_WIDTH;
    localparam int WW = $clog2(max3(T_RCD, T_RP, T_RFC) + 1);
    localparam logic [WW-1:0] RCD_LD = WW'(T_RCD - 1);
    localparam logic [WW-1:0] RP_LD  = WW'(T_RP - 1);
    localparam logic [WW-1:0] RFC_LD = WW'(T_RFC - 1);
    localparam logic [SDRAM_ROW_WIDTH-1:0] PREA_ADDR = SDRAM_ROW_WIDTH'(1) << PREA_ADDR_BIT;

    sched_state_e                 state_q;
    logic [WW-1:0]                wait_q;
    logic                         ready_q;
    logic                         cmd_valid_q;
    sdram_cmd_e                   cmd_q;
    logic [SDRAM_BANK_WIDTH-1:0]  cmd_bank_q;
    logic [SDRAM_ROW_WIDTH-1:0]   cmd_addr_q;
    logic                         write_q;
    logic [SDRAM_BANK_WIDTH-1:0]  bank_q;
    logic [SDRAM_ROW_WIDTH-1:0]   row_q;
    logic [SDRAM_COL_WIDTH-1:0]   col_q;
    logic [NB-1:0]                row_valid_q;
    logic [SDRAM_ROW_WIDTH-1:0]   row_addr_q [NB];

    logic refresh_pending_s;
    logic ref_clear_s;
    logic req_open_s;
    logic req_hit_s;
    logic any_open_s;

    // The pending flag drops while REF is on the bus.
    assign ref_clear_s = (state_q == ST_REF);

    sdram_refresh_timer #(
        .T_REF (T_REF)
    ) u_refresh_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (ref_clear_s),
        .pending_o (refresh_pending_s)
    );

    assign req_open_s  = row_valid_q[req_bank_i];
    assign req_hit_s   = req_open_s && (row_addr_q[req_bank_i] == req_row_i);
    assign any_open_s  = |row_valid_q;

    // Refresh has priority: a pending refresh closes the door to new requests.
    assign req_ready_o       = ready_q && !refresh_pending_s;
    assign cmd_valid_o       = cmd_valid_q;
    assign cmd_o             = cmd_q;
    assign cmd_bank_o        = cmd_bank_q;
    assign cmd_addr_o        = cmd_addr_q;
    assign refresh_pending_o = refresh_pending_s;

    // Scheduler FSM: state names the command on the bus this cycle; bus outputs and the open-row table update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            ready_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            cmd_bank_q  <= '0;
            cmd_addr_q  <= '0;
            write_q     <= 1'b0;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            row_valid_q <= '0;
            for (int i = 0; i < NB; i++) begin
                row_addr_q[i] <= '0;
            end
        end else begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            cmd_bank_q  <= '0;
            cmd_addr_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (refresh_pending_s) begin
                        ready_q     <= 1'b0;
                        cmd_valid_q <= 1'b1;
                        if (any_open_s) begin
                            state_q     <= ST_PREA;
                            cmd_q       <= CMD_PREA;
                            cmd_addr_q  <= PREA_ADDR;
                            wait_q      <= RP_LD;
                            row_valid_q <= '0;
                        end else begin
                            state_q <= ST_REF;
                            cmd_q   <= CMD_REF;
                            wait_q  <= RFC_LD;
                        end
                    end else if (req_valid_i && ready_q) begin
                        ready_q     <= 1'b0;
                        write_q     <= req_write_i;
                        bank_q      <= req_bank_i;
                        row_q       <= req_row_i;
                        col_q       <= req_col_i;
                        cmd_valid_q <= 1'b1;
                        cmd_bank_q  <= req_bank_i;
                        if (req_hit_s) begin
                            state_q    <= ST_RW;
                            cmd_q      <= req_write_i ? CMD_WR : CMD_RD;
                            cmd_addr_q <= SDRAM_ROW_WIDTH'(req_col_i);
                        end else if (req_open_s) begin
                            state_q                 <= ST_PRE;
                            cmd_q                   <= CMD_PRE;
                            wait_q                  <= RP_LD;
                            row_valid_q[req_bank_i] <= 1'b0;
                        end else begin
                            state_q                 <= ST_ACT;
                            cmd_q                   <= CMD_ACT;
                            cmd_addr_q              <= req_row_i;
                            wait_q                  <= RCD_LD;
                            row_valid_q[req_bank_i] <= 1'b1;
                            row_addr_q[req_bank_i]  <= req_row_i;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_ACT, ST_WAIT_RCD: begin
                    if (wait_q == '0) begin
                        state_q     <= ST_RW;
                        cmd_valid_q <= 1'b1;
                        cmd_q       <= write_q ? CMD_WR : CMD_RD;
                        cmd_bank_q  <= bank_q;
                        cmd_addr_q  <= SDRAM_ROW_WIDTH'(col_q);
                    end else begin
                        state_q <= ST_WAIT_RCD;
                        wait_q  <= wait_q - WW'(1);
                    end
                end
                ST_RW: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                ST_PRE, ST_WAIT_RP: begin
                    if (wait_q == '0) begin
                        state_q             <= ST_ACT;
                        cmd_valid_q         <= 1'b1;
                        cmd_q               <= CMD_ACT;
                        cmd_bank_q          <= bank_q;
                        cmd_addr_q          <= row_q;
                        wait_q              <= RCD_LD;
                        row_valid_q[bank_q] <= 1'b1;
                        row_addr_q[bank_q]  <= row_q;
                    end else begin
                        state_q <= ST_WAIT_RP;
                        wait_q  <= wait_q - WW'(1);
                    end
                end
                ST_PREA, ST_WAIT_RPA: begin
                    if (wait_q == '0) begin
                        state_q     <= ST_REF;
                        cmd_valid_q <= 1'b1;
                        cmd_q       <= CMD_REF;
                        wait_q      <= RFC_LD;
                    end else begin
                        state_q <= ST_WAIT_RPA;
                        wait_q  <= wait_q - WW'(1);
                    end
                end
                ST_REF, ST_WAIT_RFC: begin
                    if (wait_q == '0) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT_RFC;
                        wait_q  <= wait_q - WW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
// Bench for sdram_cmd_scheduler: a table of accesses with expected hit/closed/miss
// behaviour, plus hand-written refresh and reset sequences. Expected bus commands
// (with the cycle they must appear in) go into a queue when stimulus is driven and
// are popped by a negedge monitor whenever the DUT strobes cmd_valid_o.
module tb_sdram_cmd_scheduler;
    import sdram_pkg::*;

    localparam int T_RCD = 3;
    localparam int T_RP  = 3;
    localparam int T_RFC = 9;
    localparam int T_REF = 1560;
    localparam int K_HIT = 0;
    localparam int K_CLOSED = 1;
    localparam int K_MISS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_bank = '0;
    logic [12:0] req_row = '0;
    logic [8:0]  req_col = '0;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [1:0]  cmd_bank;
    logic [12:0] cmd_addr;
    logic        pending;

    int cyc = 0;
    int checks = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  cmd;
        logic [1:0]  bank;
        logic [12:0] addr;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        w;
        logic [1:0]  b;
        logic [12:0] r;
        logic [8:0]  c;
        int          kind;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[8];

    sdram_cmd_scheduler dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_write_i       (req_write),
        .req_bank_i        (req_bank),
        .req_row_i         (req_row),
        .req_col_i         (req_col),
        .cmd_valid_o       (cmd_valid),
        .cmd_o             (cmd),
        .cmd_bank_o        (cmd_bank),
        .cmd_addr_o        (cmd_addr),
        .refresh_pending_o (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_exp(input logic [2:0] c, input logic [1:0] b,
                                     input logic [12:0] a, input int t);
        exp_t e;
        e.cmd = c; e.bank = b; e.addr = a; e.cyc = t;
        exp_q.push_back(e);
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_ready(output bit ok);
        int t;
        t = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        ok = (req_ready === 1'b1);
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL ready_timeout cyc=%0d actual ready=%b required ready=1", cyc, req_ready);
        end
    endtask

    task automatic drive_req(input logic w, input logic [1:0] b, input logic [12:0] r, input logic [8:0] c);
        req_write = w; req_bank = b; req_row = r; req_col = c; req_valid = 1'b1;
    endtask

    // One access: wait for ready, accept, queue the expected command train, check ready around completion.
    task automatic do_access(input vec_t v);
        bit ok;
        int n;
        int t;
        wait_ready(ok);
        if (ok) begin
            n = cyc;
            drive_req(v.w, v.b, v.r, v.c);
            t = n + 1;
            if (v.kind == K_MISS) begin
                push_exp(CMD_PRE, v.b, 13'd0, t);
                t = t + T_RP;
            end
            if (v.kind != K_HIT) begin
                push_exp(CMD_ACT, v.b, v.r, t);
                t = t + T_RCD;
            end
            push_exp(v.w ? CMD_WR : CMD_RD, v.b, {4'd0, v.c}, t);
            @(posedge clk);
            #1 req_valid = 1'b0;
            wait_cyc(t);
            check_val("ready_during_rw", {31'd0, req_ready}, 32'd0);
            wait_cyc(t + 1);
            check_val("ready_after_rw", {31'd0, req_ready}, 32'd1);
        end
    endtask

    task automatic do_reset(output int r);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        r = cyc;
    endtask

    initial begin
        bit   ok;
        int   n;
        int   p;
        int   r;
        int   t;
        vec_t v;

        vecs[0] = '{1'b1, 2'd0, 13'd10,   9'd5,   K_CLOSED};
        vecs[1] = '{1'b0, 2'd0, 13'd10,   9'd6,   K_HIT};
        vecs[2] = '{1'b0, 2'd0, 13'd11,   9'd0,   K_MISS};
        vecs[3] = '{1'b1, 2'd1, 13'd5,    9'd511, K_CLOSED};
        vecs[4] = '{1'b0, 2'd3, 13'd8191, 9'd0,   K_CLOSED};
        vecs[5] = '{1'b1, 2'd0, 13'd11,   9'd1,   K_HIT};
        vecs[6] = '{1'b0, 2'd1, 13'd5,    9'd3,   K_HIT};
        vecs[7] = '{1'b1, 2'd3, 13'd0,    9'd2,   K_MISS};

        fork
            forever begin
                @(negedge clk);
                if (!rst && cmd_valid === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL cmd_unexpected cyc=%0d actual cmd=%0d bank=%0d addr=0x%0h required none",
                                 cyc, cmd, cmd_bank, cmd_addr);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (cmd !== mon_e.cmd || cmd_bank !== mon_e.bank ||
                            cmd_addr !== mon_e.addr || cyc != mon_e.cyc) begin
                            fails++;
                            $display("FAIL cmd_seq actual cmd=%0d bank=%0d addr=0x%0h cyc=%0d required cmd=%0d bank=%0d addr=0x%0h cyc=%0d",
                                     cmd, cmd_bank, cmd_addr, cyc, mon_e.cmd, mon_e.bank, mon_e.addr, mon_e.cyc);
                        end
                    end
                end else if (!rst && cmd !== 3'd0) begin
                    checks++;
                    fails++;
                    $display("FAIL cmd_not_nop cyc=%0d actual cmd=%0d required 0", cyc, cmd);
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check_val("rst_cmd", {29'd0, cmd}, 32'd0);
        check_val("rst_bank", {30'd0, cmd_bank}, 32'd0);
        check_val("rst_addr", {19'd0, cmd_addr}, 32'd0);
        check_val("rst_ready", {31'd0, req_ready}, 32'd0);
        check_val("rst_pending", {31'd0, pending}, 32'd0);
        rst = 1'b0;

        // Table of accesses: closed, hit and miss cases against the open-row table
        for (int i = 0; i < 8; i++) begin
            do_access(vecs[i]);
        end

        // Refresh while idle with banks open: PREA then REF, ready after tRFC
        t = 0;
        while (pending !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_val("refresh_raised", {31'd0, pending}, 32'd1);
        p = cyc;
        check_val("ready_blocked_by_refresh", {31'd0, req_ready}, 32'd0);
        push_exp(CMD_PREA, 2'd0, 13'h0400, p + 1);
        push_exp(CMD_REF, 2'd0, 13'd0, p + 1 + T_RP);
        wait_cyc(p + T_RP + T_RFC);
        check_val("ready_during_rfc", {31'd0, req_ready}, 32'd0);
        wait_cyc(p + 1 + T_RP + T_RFC);
        check_val("ready_after_rfc", {31'd0, req_ready}, 32'd1);
        check_val("pending_cleared", {31'd0, pending}, 32'd0);
        v = '{1'b0, 2'd1, 13'd5, 9'd7, K_CLOSED};
        do_access(v);

        // Refresh tick during a row-miss sequence with req_valid held high
        do_reset(r);
        v = '{1'b0, 2'd2, 13'd1, 9'd0, K_CLOSED};
        do_access(v);
        wait_cyc(r + T_REF - 4);
        check_val("ready_before_miss", {31'd0, req_ready}, 32'd1);
        n = cyc;
        drive_req(1'b0, 2'd2, 13'd2, 9'd4);
        push_exp(CMD_PRE,  2'd2, 13'd0,      n + 1);
        push_exp(CMD_ACT,  2'd2, 13'd2,      n + 4);
        push_exp(CMD_RD,   2'd2, 13'd4,      n + 7);
        push_exp(CMD_PREA, 2'd0, 13'h0400,   n + 9);
        push_exp(CMD_REF,  2'd0, 13'd0,      n + 12);
        push_exp(CMD_ACT,  2'd2, 13'd3,      n + 22);
        push_exp(CMD_WR,   2'd2, 13'd8,      n + 25);
        @(posedge clk);
        #1 drive_req(1'b1, 2'd2, 13'd3, 9'd8);
        wait_cyc(n + 8);
        check_val("miss_ready_after_rd", {31'd0, req_ready}, 32'd0);
        check_val("miss_pending_after_rd", {31'd0, pending}, 32'd1);
        wait_cyc(n + 20);
        check_val("held_valid_not_taken", {31'd0, req_ready}, 32'd0);
        wait_cyc(n + 21);
        check_val("held_valid_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_cyc(n + 26);
        check_val("ready_after_held_wr", {31'd0, req_ready}, 32'd1);

        // Reset between ACT and RD aborts the access
        wait_ready(ok);
        if (ok) begin
            n = cyc;
            drive_req(1'b1, 2'd1, 13'd4, 9'd9);
            @(posedge clk);
            #1 req_valid = 1'b0;
            check_val("abort_act_valid", {31'd0, cmd_valid}, 32'd1);
            check_val("abort_act_cmd", {29'd0, cmd}, {29'd0, CMD_ACT});
            rst = 1'b1;
            #1;
            check_val("abort_rst_valid", {31'd0, cmd_valid}, 32'd0);
            check_val("abort_rst_cmd", {29'd0, cmd}, 32'd0);
            check_val("abort_rst_addr", {19'd0, cmd_addr}, 32'd0);
            check_val("abort_rst_bank", {30'd0, cmd_bank}, 32'd0);
            check_val("abort_rst_ready", {31'd0, req_ready}, 32'd0);
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (10) @(negedge clk);
            v = '{1'b1, 2'd1, 13'd4, 9'd10, K_CLOSED};
            do_access(v);
        end

        repeat (5) @(negedge clk);
        check_val("expected_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
